debug_step_ctrl: RTL
====================

Name: debug_step_ctrl

Overview:
- Debug-side execution controller that drives the pipeline step enable sampled by every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB).
- Takes single-byte commands from the UART receiver and runs the pipeline either continuously or one cycle at a time.
- After each run or step it reports the executed-cycle count to the UART transmitter as 4 bytes, LSB first.
- Runs on posedge. Pipeline registers capture on negedge, so a one-cycle-high o_step is seen by exactly one pipeline capture.

Parameters:
- NB, 32, width of the cycle counter and of the report value
- NB_DATA, 8, UART byte width
- CMD_RUN, 8'h63, command byte for continuous run
- CMD_STEP, 8'h73, command byte for single step
- CMD_STOP, 8'h78, command byte to stop a continuous run

Ports:
- i_clk  in  1  system clock; all state updates on posedge
- i_reset  in  1  asynchronous, active-low reset; one clock domain
- i_rx_data  in  NB_DATA  received command byte
- i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid in that cycle
- i_halt  in  1  level; a HALT instruction has reached writeback
- i_tx_done  in  1  one-cycle pulse from the UART transmitter when the current byte finishes
- o_step  out  1  pipeline advance enable; high for exactly the cycles in which the pipeline must advance
- o_tx_data  out  NB_DATA  byte to transmit
- o_tx_start  out  1  one-cycle pulse that starts transmission of o_tx_data
- o_cycle_count  out  NB  number of cycles o_step has been high since reset
- o_halted  out  1  controller has latched a halt; stays high until reset

Behaviour:
- Reset (i_reset low, asynchronous):
  - o_step=0, o_tx_start=0, o_tx_data=0, o_cycle_count=0, o_halted=0.
  - State IDLE, byte index 0.
  - A reset asserted mid-RUN or mid-SEND aborts immediately; no partial report resumes afterwards.
- States: IDLE, RUN, STEP, SEND, HALTED. State is a registered encoding.
- o_step is decoded from the state register: high only in RUN and STEP. No combinational path from any input to o_step.
- o_cycle_count increments by 1 on every posedge at which o_step is high. It wraps from 2^NB-1 to 0.
- IDLE:
  - i_rx_valid with CMD_RUN -> RUN.
  - i_rx_valid with CMD_STEP -> STEP.
  - Any other byte is ignored.
  - If i_halt is high when a RUN/STEP command arrives: go to SEND with no step issued, and set o_halted.
- RUN:
  - o_step high every cycle.
  - At a posedge with i_halt=1: set o_halted, go to SEND. The cycle in which the halt was sampled counts as a step.
  - i_rx_valid with CMD_STOP -> SEND; that cycle also counts.
  - Other bytes are ignored.
  - If halt and STOP arrive in the same cycle, halt wins (o_halted set).
- STEP:
  - Lasts exactly one cycle (o_step high for one cycle), then SEND unconditionally.
  - If i_halt is high in that cycle, o_halted is set.
- SEND:
  - Byte index k=0..3. o_tx_data = o_cycle_count[8k+7:8k], using the count value captured on SEND entry.
  - o_tx_start pulses one cycle at SEND entry and again in the cycle after each i_tx_done, until 4 bytes have completed.
  - After the 4th i_tx_done: go to HALTED if o_halted, else IDLE.
  - All rx commands are dropped in SEND.
  - i_tx_done outside SEND is ignored.
- HALTED:
  - o_step stays 0. All commands are ignored. Exit only by reset.
- Only one o_tx_start is outstanding at a time. o_tx_data is stable from o_tx_start until the matching i_tx_done.

Test Plan:
- Reset then CMD_STEP -> o_step high exactly 1 cycle; o_cycle_count=1; tx bytes 01,00,00,00 with 4 o_tx_start pulses, each after the prior i_tx_done; back to IDLE.
- CMD_RUN, i_halt rises after 10 step cycles (sampled on the 10th) -> o_step high 10 cycles, count=10, o_halted=1; tx 0A,00,00,00; then CMD_STEP/CMD_RUN produce no o_step.
- CMD_RUN, CMD_STOP after 300 cycles -> count=300; tx 2C,01,00,00; o_halted=0; a following CMD_STEP gives count=301.
- i_halt already high in IDLE, send CMD_STEP -> no o_step pulse, count unchanged, one report sent, o_halted=1.
- CMD_STEP and unknown byte 0x41 sent during SEND, plus stray i_tx_done in IDLE -> all ignored; exactly 4 bytes transmitted; no extra step.
- Reset asserted low mid-RUN and again mid-SEND after byte 1 -> all outputs zero immediately (asynchronously); no further tx pulses after release.
- Counter preloaded via forced state to 2^32-1, then CMD_STEP -> count wraps to 0; tx 00,00,00,00.

Source files
------------

// File: rtl/debug_step_ctrl.sv
// ---------------------------------------------------------------------------
// debug_step_ctrl
//   Debug-side execution controller. Decodes single-byte UART commands and
//   drives the pipeline step enable, either continuously (run) or for a single
//   cycle (step). After every run/step it reports the executed-cycle count to
//   the UART transmitter as NB/NB_DATA bytes, LSB first.
//
// Ports:
//   i_clk          system clock, all state updates on posedge
//   i_reset        asynchronous active-low reset
//   i_rx_data      received command byte
//   i_rx_valid     one-cycle pulse qualifying i_rx_data
//   i_halt         level, HALT instruction has reached writeback
//   i_tx_done      one-cycle pulse when the transmitter finishes a byte
//   o_step         pipeline advance enable (registered state decode only)
//   o_tx_data      byte to transmit
//   o_tx_start     one-cycle pulse starting transmission of o_tx_data
//   o_cycle_count  number of cycles o_step has been high since reset
//   o_halted       sticky halt flag, cleared only by reset
// ---------------------------------------------------------------------------
module debug_step_ctrl #(
    parameter int unsigned          NB       = 32,
    parameter int unsigned          NB_DATA  = 8,
    parameter logic [NB_DATA-1:0]   CMD_RUN  = 8'h63,
    parameter logic [NB_DATA-1:0]   CMD_STEP = 8'h73,
    parameter logic [NB_DATA-1:0]   CMD_STOP = 8'h78
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_halt,
    input  logic               i_tx_done,
    output logic               o_step,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic [NB-1:0]      o_cycle_count,
    output logic               o_halted
);

    localparam int unsigned NBYTES = NB / NB_DATA;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StStep,
        StSend,
        StHalted
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic             r_tx_start;
    logic             w_tx_start_next;
    logic             r_halted;
    logic             w_halt_set;
    logic [NB-1:0]    r_count;
    logic [NB-1:0]    w_shifted;
    logic             w_step;
    logic             w_is_go_cmd;

    assign w_step      = (r_state == StRun) || (r_state == StStep);
    assign w_is_go_cmd = i_rx_valid && ((i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP));

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_tx_start_next = 1'b0;
        w_halt_set      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_is_go_cmd) begin
                    if (i_halt) begin
                        // Already halted: report without issuing a step.
                        w_halt_set   = 1'b1;
                        w_state_next = StSend;
                    end else if (i_rx_data == CMD_RUN) begin
                        w_state_next = StRun;
                    end else begin
                        w_state_next = StStep;
                    end
                end
            end
            StRun: begin
                // Halt has priority over STOP so o_halted is never lost.
                if (i_halt) begin
                    w_halt_set   = 1'b1;
                    w_state_next = StSend;
                end else if (i_rx_valid && (i_rx_data == CMD_STOP)) begin
                    w_state_next = StSend;
                end
            end
            StStep: begin
                w_halt_set   = i_halt;
                w_state_next = StSend;
            end
            StSend: begin
                if (i_tx_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = (r_halted) ? StHalted : StIdle;
                    end else begin
                        w_idx_next      = r_idx + 1'b1;
                        w_tx_start_next = 1'b1;
                    end
                end
            end
            StHalted: begin
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        // First byte starts in the first SEND cycle.
        if ((w_state_next == StSend) && (r_state != StSend)) begin
            w_tx_start_next = 1'b1;
            w_idx_next      = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_tx_start <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_tx_start <= w_tx_start_next;
            if (w_halt_set) begin
                r_halted <= 1'b1;
            end
            if (w_step) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // The counter is frozen throughout SEND, so it is the value captured on entry.
    assign w_shifted = r_count >> (int'(r_idx) * NB_DATA);

    assign o_step        = w_step;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = (r_state == StSend) ? w_shifted[NB_DATA-1:0] : '0;
    assign o_cycle_count = r_count;
    assign o_halted      = r_halted;

endmodule
